// File: rtl/rtc_bus_arbiter_pkg.sv
// Shared constants for the RTC bus arbiter: bus width, default phase length
// and the 3-bit state encoding.
package rtc_bus_pkg;

   localparam int RTC_DW          = 8;
   localparam int RTC_T_PHASE_DEF = 4;

   localparam logic [2:0] ST_IDLE        = 3'd0;
   localparam logic [2:0] ST_ADDR_SETUP  = 3'd1;
   localparam logic [2:0] ST_ADDR_STROBE = 3'd2;
   localparam logic [2:0] ST_ADDR_HOLD   = 3'd3;
   localparam logic [2:0] ST_DATA_SETUP  = 3'd4;
   localparam logic [2:0] ST_DATA_STROBE = 3'd5;
   localparam logic [2:0] ST_DATA_HOLD   = 3'd6;
   localparam logic [2:0] ST_DONE        = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE        = ST_IDLE,
      S_ADDR_SETUP  = ST_ADDR_SETUP,
      S_ADDR_STROBE = ST_ADDR_STROBE,
      S_ADDR_HOLD   = ST_ADDR_HOLD,
      S_DATA_SETUP  = ST_DATA_SETUP,
      S_DATA_STROBE = ST_DATA_STROBE,
      S_DATA_HOLD   = ST_DATA_HOLD,
      S_DONE        = ST_DONE
   } rtc_state_t;

endpackage

// File: rtl/rtc_bus_arbiter_rr_pick.sv
// One-hot requester selector: round-robin from i_ptr, or lowest index wins
// when RTC_ARB_FIXED_PRIO_EN is defined.
module rtc_rr_pick #(
   parameter int NREQ = 3,
   parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [PW-1:0]   i_ptr,
   output logic [NREQ-1:0] o_win
);

   logic w_found;

`ifdef RTC_ARB_FIXED_PRIO_EN
   wire w_unused_ptr = ^i_ptr;

   always_comb begin
      o_win   = '0;
      w_found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!w_found && i_req[i]) begin
            o_win[i] = 1'b1;
            w_found  = 1'b1;
         end
      end
   end
`else
   // Search offset k from the pointer; the first requester found at offset k wins.
   always_comb begin
      o_win   = '0;
      w_found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!w_found && i_req[i] && (((int'(i_ptr) + k) % NREQ) == i)) begin
               o_win[i] = 1'b1;
               w_found  = 1'b1;
            end
         end
      end
   end
`endif

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Arbitrates NREQ requesters onto the multiplexed RTC bus and runs one address+data cycle.
// Req is a level sampled in IDLE; once granted the cycle always completes and Listo pulses once.
module rtc_bus_arbiter
   import rtc_bus_pkg::*;
#(
   parameter int NREQ    = 3,
   parameter int T_PHASE = RTC_T_PHASE_DEF
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic [NREQ-1:0]          Req,
   input  logic [NREQ-1:0]          Wr_Req,
   input  logic [RTC_DW*NREQ-1:0]   Dir_In,
   input  logic [RTC_DW*NREQ-1:0]   Dato_In,
   output logic [NREQ-1:0]          Grant,
   output logic [NREQ-1:0]          Listo,
   output logic [RTC_DW-1:0]        Dato_Leido,
   output logic [RTC_DW-1:0]        Bus_Out,
   output logic                     Bus_Oe,
   input  logic [RTC_DW-1:0]        Bus_In,
   output logic                     AD,
   output logic                     RD,
   output logic                     WR,
   output logic                     CS,
   output logic [2:0]               Dbg_State
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;

   rtc_state_t        r_state, w_next;
   logic [CW-1:0]     r_cnt;
   logic [PW-1:0]     r_ptr;
   logic [NREQ-1:0]   r_win;
   logic [RTC_DW-1:0] r_addr, r_data, r_rcap, r_dato;
   logic              r_wr;

   logic [NREQ-1:0]   w_pick;
   logic [RTC_DW-1:0] w_sel_addr, w_sel_data;
   logic              w_sel_wr;
   logic [PW-1:0]     w_win_idx, w_ptr_nxt;
   logic              w_phase_end;

   rtc_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
      .i_req (Req),
      .i_ptr (r_ptr),
      .o_win (w_pick)
   );

   always_comb begin
      w_sel_addr = '0;
      w_sel_data = '0;
      w_sel_wr   = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_pick[i]) begin
            w_sel_addr = Dir_In[RTC_DW*i +: RTC_DW];
            w_sel_data = Dato_In[RTC_DW*i +: RTC_DW];
            w_sel_wr   = Wr_Req[i];
         end
      end
   end

   always_comb begin
      w_win_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (r_win[i]) w_win_idx = PW'(i);
      end
   end

   assign w_ptr_nxt   = (w_win_idx == PW'(NREQ - 1)) ? '0 : w_win_idx + PW'(1);
   assign w_phase_end = (r_cnt == CW'(T_PHASE - 1));

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:        if (|Req)       w_next = S_ADDR_SETUP;
         S_ADDR_SETUP:  if (w_phase_end) w_next = S_ADDR_STROBE;
         S_ADDR_STROBE: if (w_phase_end) w_next = S_ADDR_HOLD;
         S_ADDR_HOLD:   if (w_phase_end) w_next = S_DATA_SETUP;
         S_DATA_SETUP:  if (w_phase_end) w_next = S_DATA_STROBE;
         S_DATA_STROBE: if (w_phase_end) w_next = S_DATA_HOLD;
         S_DATA_HOLD:   if (w_phase_end) w_next = S_DONE;
         S_DONE:                         w_next = S_IDLE;
         default:                        w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_ptr   <= '0;
         r_win   <= '0;
         r_addr  <= '0;
         r_data  <= '0;
         r_wr    <= 1'b0;
         r_rcap  <= '0;
         r_dato  <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE || r_state == S_DONE || w_phase_end) r_cnt <= '0;
         else                                                       r_cnt <= r_cnt + CW'(1);
         if (r_state == S_IDLE && |Req) begin
            r_win  <= w_pick;
            r_addr <= w_sel_addr;
            r_data <= w_sel_data;
            r_wr   <= w_sel_wr;
         end
         // Pad data is sampled at the end of the strobe but only published with Listo.
         if (r_state == S_DATA_STROBE && w_phase_end && !r_wr) r_rcap <= Bus_In;
         if (r_state == S_DATA_HOLD && w_phase_end && !r_wr)   r_dato <= r_rcap;
`ifdef RTC_ARB_FIXED_PRIO_EN
         r_ptr <= '0;
`else
         if (r_state == S_DONE) r_ptr <= w_ptr_nxt;
`endif
      end
   end

   always_comb begin
      CS      = 1'b1;
      AD      = 1'b1;
      RD      = 1'b1;
      WR      = 1'b1;
      Bus_Oe  = 1'b0;
      Bus_Out = '0;
      Grant   = '0;
      Listo   = '0;
      case (r_state)
         S_ADDR_SETUP, S_ADDR_STROBE, S_ADDR_HOLD: begin
            CS      = 1'b0;
            AD      = 1'b0;
            Bus_Oe  = 1'b1;
            Bus_Out = r_addr;
            Grant   = r_win;
            if (r_state == S_ADDR_STROBE) WR = 1'b0;
         end
         S_DATA_SETUP, S_DATA_STROBE, S_DATA_HOLD: begin
            CS    = 1'b0;
            Grant = r_win;
            if (r_wr) begin
               Bus_Oe  = 1'b1;
               Bus_Out = r_data;
            end
            if (r_state == S_DATA_STROBE) begin
               if (r_wr) WR = 1'b0;
               else      RD = 1'b0;
            end
         end
         S_DONE:  Listo = r_win;
         default: ;
      endcase
   end

   assign Dato_Leido = r_dato;
   assign Dbg_State  = r_state;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Directed bench for rtc_bus_arbiter (NREQ=3, T_PHASE=4) with a Listo-driven scoreboard.
module tb_rtc_bus_arbiter;

   logic        clk = 1'b0;
   logic        Reset;
   logic [2:0]  Req, Wr_Req, Grant, Listo;
   logic [23:0] Dir_In, Dato_In;
   logic [7:0]  Dato_Leido, Bus_Out, Bus_In;
   logic        Bus_Oe, AD, RD, WR, CS;
   logic [2:0]  Dbg_State;

   int tests = 0;
   int fails = 0;
   // {is_read, listo one-hot, read data}
   logic [11:0] exp_q[$];

   rtc_bus_arbiter #(.NREQ(3), .T_PHASE(4)) dut (
      .Clock(clk), .Reset(Reset), .Req(Req), .Wr_Req(Wr_Req),
      .Dir_In(Dir_In), .Dato_In(Dato_In), .Grant(Grant), .Listo(Listo),
      .Dato_Leido(Dato_Leido), .Bus_Out(Bus_Out), .Bus_Oe(Bus_Oe), .Bus_In(Bus_In),
      .AD(AD), .RD(RD), .WR(WR), .CS(CS), .Dbg_State(Dbg_State)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Scoreboard: every Listo pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      logic [11:0] e;
      if (!Reset && |Listo) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected at %0t: got listo=%0h expected none", $time, Listo);
         end else begin
            e = exp_q.pop_front();
            if (Listo !== e[10:8] || (e[11] && Dato_Leido !== e[7:0])) begin
               fails++;
               $display("FAIL sb_listo at %0t: got listo=%0h data=%0h expected listo=%0h data=%0h",
                        $time, Listo, Dato_Leido, e[10:8], e[7:0]);
            end
         end
      end
   end

   // Strobe invariants checked every cycle.
   always @(negedge clk) begin
      tests++;
      if ((RD === 1'b0 && WR === 1'b0) || (CS === 1'b1 && (RD === 1'b0 || WR === 1'b0))) begin
         fails++;
         $display("FAIL strobe_inv at %0t: got cs=%0b rd=%0b wr=%0b", $time, CS, RD, WR);
      end
   end

   task automatic chk_idle(input string tag);
      chk({tag, "_cs"}, CS, 1);
      chk({tag, "_ad"}, AD, 1);
      chk({tag, "_rd"}, RD, 1);
      chk({tag, "_wr"}, WR, 1);
      chk({tag, "_oe"}, Bus_Oe, 0);
      chk({tag, "_out"}, Bus_Out, 8'h00);
      chk({tag, "_grant"}, Grant, 3'b000);
      chk({tag, "_listo"}, Listo, 3'b000);
      chk({tag, "_dato"}, Dato_Leido, 8'h00);
      chk({tag, "_state"}, Dbg_State, 3'd0);
   endtask

   // Cycle 0 is the IDLE cycle in which Req is sampled; checks run mid-cycle.
   task automatic run_txn(input logic [2:0] mask, input int who, input logic wr,
                          input logic [7:0] dir, input logic [7:0] dato, input logic [7:0] rdval,
                          input int drop_k, input int rst_k, input int last_k, input logic push);
      logic [2:0] g;
      g = 3'b001 << who;
      @(posedge clk); #1;
      Req = mask;
      for (int i = 0; i < 3; i++) begin
         if (mask[i]) begin
            Wr_Req[i]        = wr;
            Dir_In[8*i +: 8]  = dir;
            Dato_In[8*i +: 8] = dato;
         end
      end
      if (push) exp_q.push_back({~wr, g, wr ? 8'h00 : rdval});
      for (int k = 0; k <= last_k; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         Bus_In = (!wr && k >= 17 && k <= 20) ? rdval : 8'hEE;
         if (k == drop_k) Req = 3'b000;
         if (k == 2) begin
            Wr_Req  = ~Wr_Req;
            Dir_In  = ~Dir_In;
            Dato_In = ~Dato_In;
         end
         if (k == rst_k) Reset = 1'b1;
         @(negedge clk);
         if (k == 0) begin
            chk("idle_cs", CS, 1);
            chk("idle_grant", Grant, 3'b000);
         end else if (k <= 24) begin
            chk("cs", CS, 0);
            chk("grant", Grant, g);
            chk("ad", AD, (k > 12));
            if (k <= 12) begin
               chk("addr_out", Bus_Out, dir);
               chk("addr_oe", Bus_Oe, 1);
            end else if (wr) begin
               chk("data_out", Bus_Out, dato);
               chk("data_oe", Bus_Oe, 1);
            end else begin
               chk("rd_oe", Bus_Oe, 0);
            end
            chk("wr", WR, !((k >= 5 && k <= 8) || (wr && k >= 17 && k <= 20)));
            chk("rd", RD, !(!wr && k >= 17 && k <= 20));
         end else begin
            chk("done_cs", CS, 1);
            chk("done_grant", Grant, 3'b000);
         end
         chk("listo", Listo, (k == 25) ? g : 3'b000);
      end
   endtask

   initial begin
      int ord[4];
      logic [2:0] gexp;
      ord = '{0, 1, 2, 0};
      Reset   = 1'b1;
      Req     = 3'($urandom_range(1, 7));
      Wr_Req  = 3'($urandom_range(0, 7));
      Dir_In  = 24'($urandom);
      Dato_In = 24'($urandom);
      Bus_In  = 8'hEE;

      // Reset
      @(posedge clk); #1;
      Req = 3'($urandom_range(1, 7));
      @(posedge clk);
      @(negedge clk);
      chk_idle("rst");
      Req = 3'b000;
      @(posedge clk); #1;
      Reset = 1'b0;

      // Write, read, dropped request: pointer walks 0 -> 1 -> 2 -> 0
      run_txn(3'b001, 0, 1'b1, 8'h21, 8'h15, 8'h00, 1, -1, 25, 1'b1);
      run_txn(3'b010, 1, 1'b0, 8'h25, 8'h00, 8'h04, 1, -1, 25, 1'b1);
      run_txn(3'b100, 2, 1'b1, 8'h2A, 8'h5C, 8'h00, 3, -1, 25, 1'b1);
      chk("dato_hold", Dato_Leido, 8'h04);

      // Contention with all requests held
      @(posedge clk); #1;
      Req     = 3'b111;
      Wr_Req  = 3'b111;
      Dir_In  = {8'h32, 8'h31, 8'h30};
      Dato_In = {8'h62, 8'h61, 8'h60};
      for (int n = 0; n < 4; n++) exp_q.push_back({1'b0, 3'(3'b001 << ord[n]), 8'h00});
      for (int k = 0; k <= 103; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         @(negedge clk);
         gexp = 3'b001 << ord[k / 26];
         if ((k % 26) == 1) begin
            chk("rr_grant", Grant, gexp);
            chk("rr_addr", Bus_Out, 8'h30 + 8'(ord[k / 26]));
         end
         chk("rr_listo_slot", |Listo, ((k % 26) == 25));
         if (k == 103) Req = 3'b000;
      end

      // Reset during DATA_STROBE of a read by requester 1 (pointer is 1 here)
      run_txn(3'b010, 1, 1'b0, 8'h33, 8'h00, 8'h5A, 1, 18, 18, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      chk_idle("abort");
      Reset = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("abort_quiet", Listo, 3'b000);
      end
      run_txn(3'b011, 0, 1'b1, 8'h40, 8'h41, 8'h00, 1, -1, 25, 1'b1);

      repeat (3) @(negedge clk);
      chk("sb_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
